// File: rtl/vga_timing_generator.sv
// VGA 640x480@60 timing generator with one-pixel registered output stage.
// Optional build macro: VGA_TEST_PATTERN_EN enables a 16x16 checkerboard
// on pixel_out when test_mode=1; without it test_mode is accepted but ignored.

package vga_pkg;
    typedef struct packed {
        int unsigned pixel_x_bits;
        int unsigned pixel_y_bits;
    } vga_params_t;

    localparam vga_params_t VGA_PARAMS_DEFAULT = '{pixel_x_bits: 10, pixel_y_bits: 10};
endpackage

module vga_timing_generator #(
    parameter vga_pkg::vga_params_t params = vga_pkg::VGA_PARAMS_DEFAULT,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           pixel_en,
    output logic [params.pixel_x_bits-1:0] pixel_x_target_next,
    output logic [params.pixel_y_bits-1:0] pixel_y_target_next,
    input  logic                           pixel_value_next,
    output logic                           h_sync,
    output logic                           v_sync,
    output logic                           pixel_out,
    output logic                           video_active,
    output logic                           frame_start,
    input  logic                           test_mode
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS      = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS      = 11'(V_VISIBLE);
    localparam logic [10:0] HS_FIRST   = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_LAST    = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST   = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_LAST    = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [10:0] h_cnt;
    logic [10:0] v_cnt;

    logic h_wrap;
    logic frame_wrap;
    logic active_comb;
    logic hs_low_comb;
    logic vs_low_comb;
    logic pixel_comb;

`ifndef VGA_TEST_PATTERN_EN
    logic test_mode_unused;
    assign test_mode_unused = test_mode;
`endif

    // Coordinate requested from the decoder is the current counter position.
    assign pixel_x_target_next = h_cnt[params.pixel_x_bits-1:0];
    assign pixel_y_target_next = v_cnt[params.pixel_y_bits-1:0];

    // Decode the current counter position into region, sync and pixel values.
    always_comb begin
        h_wrap      = (h_cnt == H_LAST);
        frame_wrap  = h_wrap && (v_cnt == V_LAST);
        active_comb = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hs_low_comb = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
        vs_low_comb = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
        pixel_comb  = active_comb & pixel_value_next;
`ifdef VGA_TEST_PATTERN_EN
        if (test_mode) begin
            pixel_comb = active_comb & (h_cnt[4] ^ v_cnt[4]);
        end
`endif
    end

    // Horizontal/vertical position counters, advancing once per pixel strobe.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pixel_en) begin
            if (h_wrap) begin
                h_cnt <= '0;
                if (v_cnt == V_LAST) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + 11'd1;
                end
            end else begin
                h_cnt <= h_cnt + 11'd1;
            end
        end
    end

    // Registered video/sync outputs, one pixel behind the counter position.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            h_sync       <= 1'b1;
            v_sync       <= 1'b1;
            pixel_out    <= 1'b0;
            video_active <= 1'b0;
        end else if (pixel_en) begin
            h_sync       <= ~hs_low_comb;
            v_sync       <= ~vs_low_comb;
            pixel_out    <= pixel_comb;
            video_active <= active_comb;
        end
    end

    // Single-clock frame pulse; cleared on every clock that is not the wrap strobe.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= pixel_en & frame_wrap;
        end
    end

endmodule
